// File: rtl/line_memory_responder_pkg.sv
// Shared definitions for the line-granular backing memory: FSM states, op codes, log2 helper.
package line_memory_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_memory_responder_line_array.sv
// Line storage: synchronous write, combinational read, contents survive reset.
module line_array
    import line_memory_responder_pkg::*;
#(
    parameter int NUM_LINES = 1024,
    parameter int LINE_W    = 128
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [clog2(NUM_LINES)-1:0] widx,
    input  logic [LINE_W-1:0]           wdata,
    input  logic [clog2(NUM_LINES)-1:0] ridx,
    output logic [LINE_W-1:0]           rdata
);

    logic [LINE_W-1:0] mem [NUM_LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/line_memory_responder.sv
// Fixed-latency line memory: accepts one read/write, waits DELAY cycles, then commits or returns the line.
module line_memory_responder
    import line_memory_responder_pkg::*;
#(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_LINES  = 1024,
    parameter int DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic                    mem_ready
);

    localparam int OFF_W  = clog2(BLOCK_SIZE);
    localparam int IDX_W  = clog2(NUM_LINES);
    localparam int LINE_W = BLOCK_SIZE * 8;
    localparam int CNT_W  = clog2(DELAY) + 1;

    logic [1:0]        state;
    logic [CNT_W-1:0]  counter;
    logic              op_latched;
    logic [IDX_W-1:0]  idx_latched;
    logic [LINE_W-1:0] din_latched;
    logic [LINE_W-1:0] line_rdata;
    logic              accept;
    logic              array_we;

    // Offset bits and aliasing upper bits are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{addr[31:OFF_W+IDX_W], addr[OFF_W-1:0]};

    assign mem_ready = (state == ST_IDLE);
    assign accept    = is_input_valid && mem_ready && (mem_read ^ mem_write);
    assign array_we  = (state == ST_DONE) && (op_latched == OP_WRITE);

    line_array #(
        .NUM_LINES(NUM_LINES),
        .LINE_W   (LINE_W)
    ) u_line_array (
        .clk  (clk),
        .we   (array_we),
        .widx (idx_latched),
        .wdata(din_latched),
        .ridx (idx_latched),
        .rdata(line_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            counter         <= '0;
            is_output_valid <= 1'b0;
            dout            <= '0;
        end else begin
            is_output_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_BUSY;
                        counter <= CNT_W'(DELAY - 1);
                    end
                end
                ST_BUSY: begin
                    if (counter == '0) begin
                        state <= ST_DONE;
                        // Registering here makes dout/valid visible for exactly the DONE cycle.
                        if (op_latched == OP_READ) begin
                            dout            <= line_rdata;
                            is_output_valid <= 1'b1;
                        end
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request latches need no reset: they are only consumed after an accept reloads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_latched  <= mem_write ? OP_WRITE : OP_READ;
            idx_latched <= addr[OFF_W+IDX_W-1:OFF_W];
            din_latched <= din;
        end
    end

endmodule

// File: tb/tb_line_memory_responder.sv
// Self-checking bench: vector table, hand sequences for corner cases, random traffic vs. a line-array model.
module tb_line_memory_responder;

    localparam int BLOCK_SIZE = 16;
    localparam int NUM_LINES  = 1024;
    localparam int DELAY      = 4;
    localparam int W          = BLOCK_SIZE * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          is_input_valid = 1'b0;
    logic [31:0]   addr = '0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [W-1:0]  din = '0;
    logic          is_output_valid;
    logic [W-1:0]  dout;
    logic          mem_ready;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    int dbl_pulses = 0;
    logic prev_valid = 1'b0;
    time accept_time = 0;
    logic [W-1:0] last_dout = '0;
    logic [W-1:0] model [NUM_LINES];

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [W-1:0] d;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs [8];

    line_memory_responder #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .NUM_LINES (NUM_LINES),
        .DELAY     (DELAY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .is_input_valid (is_input_valid),
        .addr           (addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .din            (din),
        .is_output_valid(is_output_valid),
        .dout           (dout),
        .mem_ready      (mem_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (is_output_valid === 1'b1) pulses++;
        if (is_output_valid === 1'b1 && prev_valid === 1'b1) dbl_pulses++;
        prev_valid <= is_output_valid;
    end

    function automatic int line_of(input logic [31:0] a);
        return int'((a / BLOCK_SIZE) % NUM_LINES);
    endfunction

    function automatic logic [W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (mem_ready !== 1'b1 && n < 3 * DELAY + 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", W'(mem_ready), W'(1));
    endtask

    // One full transaction; checks ready/valid/dout against the DELAY latency rule every cycle.
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] exp, input bit intrude);
        wait_ready();
        is_input_valid = 1'b1; mem_read = !wr; mem_write = wr; addr = a; din = d;
        @(negedge clk);
        accept_time = $time;
        is_input_valid = 1'b0; addr = $urandom; din = rand_line();
        mem_read = 1'($urandom); mem_write = 1'($urandom);
        chk("accept_ready_low", W'(mem_ready), W'(0));
        chk("accept_valid_low", W'(is_output_valid), W'(0));
        if (intrude) begin
            is_input_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr = a; din = ~d;
        end
        for (int j = 1; j <= DELAY + 1; j++) begin
            @(negedge clk);
            is_input_valid = 1'b0;
            if (j < DELAY) begin
                chk("busy_ready", W'(mem_ready), W'(0));
                chk("busy_valid", W'(is_output_valid), W'(0));
            end else if (j == DELAY) begin
                chk("done_ready", W'(mem_ready), W'(0));
                chk("done_valid", W'(is_output_valid), W'(!wr));
                if (!wr) chk("read_data", dout, exp);
            end else begin
                chk("idle_ready", W'(mem_ready), W'(1));
                chk("idle_valid", W'(is_output_valid), W'(0));
                if (!wr) chk("dout_hold", dout, exp);
            end
        end
        if (wr) model[line_of(a)] = d;
        else last_dout = exp;
    endtask

    initial begin
        logic [W-1:0] d1, d2, d3;
        logic [31:0] a;
        bit wr;
        int p0;
        time t_prev;

        for (int i = 0; i < NUM_LINES; i++) model[i] = '0;
        d1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        d2 = 128'hDEAD_BEEF_CAFE_F00D_1111_2222_3333_4444;
        d3 = 128'h5A5A_A5A5_0F0F_F0F0_1234_5678_9ABC_DEF0;
        vecs[0] = '{1'b1, 32'h0000_0040, d1, '0};
        vecs[1] = '{1'b0, 32'h0000_0040, '0, d1};
        vecs[2] = '{1'b1, 32'h0000_4044, d2, '0};
        vecs[3] = '{1'b0, 32'h0000_0040, '0, d2};
        vecs[4] = '{1'b0, 32'h0000_0050, '0, '0};
        vecs[5] = '{1'b1, 32'hFFFF_FFF0, d3, '0};
        vecs[6] = '{1'b0, 32'h0000_3FF7, '0, d3};
        vecs[7] = '{1'b0, 32'h0000_404F, '0, d2};

        // Reset with no traffic.
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", W'(mem_ready), W'(1));
            chk("rst_valid", W'(is_output_valid), W'(0));
            chk("rst_dout", dout, '0);
        end
        reset = 1'b1;

        for (int i = 0; i < 8; i++) do_req(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp, 1'b0);

        // Illegal op encodings are ignored.
        @(negedge clk);
        is_input_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; addr = 32'h40;
        @(negedge clk);
        chk("illegal_both_ready", W'(mem_ready), W'(1));
        chk("illegal_both_valid", W'(is_output_valid), W'(0));
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("illegal_none_ready", W'(mem_ready), W'(1));
        is_input_valid = 1'b0;
        @(negedge clk);
        chk("illegal_dout_kept", dout, last_dout);

        // A request while busy is dropped; the first read completes with the original line.
        do_req(1'b0, 32'h0000_0040, '0, d2, 1'b1);
        do_req(1'b0, 32'h0000_0040, '0, d2, 1'b0);

        // Reset two cycles into a write: write discarded, ready returns at once.
        wait_ready();
        is_input_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr = 32'h80;
        din = {4{32'hAAAA_AAAA}};
        @(negedge clk);
        is_input_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ready", W'(mem_ready), W'(1));
        chk("midrst_valid", W'(is_output_valid), W'(0));
        @(negedge clk);
        reset = 1'b1;
        p0 = pulses;
        repeat (DELAY + 2) @(negedge clk);
        chk("midrst_no_pulse", W'(pulses - p0), W'(0));
        do_req(1'b0, 32'h0000_0080, '0, model[8], 1'b0);

        // Reset during a read: no pulse.
        wait_ready();
        is_input_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h40;
        @(negedge clk);
        is_input_valid = 1'b0;
        @(negedge clk);
        p0 = pulses;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (DELAY + 2) @(negedge clk);
        chk("rdrst_no_pulse", W'(pulses - p0), W'(0));

        // Back-to-back reads: accepts exactly DELAY+2 cycles apart, one pulse each.
        p0 = pulses;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            a = {$urandom_range(0, 255), 4'($urandom)} | 32'h0000_0000;
            do_req(1'b0, a, '0, model[line_of(a)], 1'b0);
            if (i > 0) chk("b2b_spacing", W'(accept_time - t_prev), W'((DELAY + 2) * 10));
            t_prev = accept_time;
        end
        chk("b2b_pulses", W'(pulses - p0), W'(4));

        // Random traffic over a few lines, with random aliasing upper bits and offsets.
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            a = ($urandom << 14) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
            if (wr) do_req(1'b1, a, rand_line(), '0, 1'($urandom));
            else    do_req(1'b0, a, '0, model[line_of(a)], 1'($urandom));
        end

        chk("no_double_pulse", W'(dbl_pulses), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
